// File: rtl/peripheral_slave_bfm_wb_if.sv
// peripheral_slave_bfm_wb_if: Wishbone B4 bus between a master and the slave front-end
interface peripheral_slave_bfm_wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;
  logic [DW-1:0]   wb_dat_o;
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/peripheral_slave_bfm_wb.sv
// peripheral_slave_bfm_wb: Wishbone B4 slave front-end forwarding beats to a user req/rsp port (burst address check under PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN)
module peripheral_slave_bfm_wb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  peripheral_slave_bfm_wb_if.slave wb,
  output logic                     req_valid,
  output logic [AW-1:0]            req_adr,
  output logic                     req_we,
  output logic [DW/8-1:0]          req_sel,
  output logic [DW-1:0]            req_wdat,
  output logic                     req_burst,
  output logic                     req_first,
  input  logic                     rsp_valid,
  input  logic                     rsp_err,
  input  logic [DW-1:0]            rsp_rdat,
  output logic [31:0]              rd_cnt,
  output logic [31:0]              wr_cnt
`ifdef PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN
  ,
  output logic                     adr_err
`endif
);
  localparam int BW = DW / 8;
`ifdef PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic go, cap, fin, mis, in_burst, bad;
  logic [2:0] cti_q;
  logic [1:0] bte_q;
  logic [AW-1:0] nxt, nxt_d, inc, msk;

  assign wb.wb_rty_o = 1'b0;
  assign go = wb.wb_cyc_i & wb.wb_stb_i;
  assign mis = CHK & in_burst & (wb.wb_adr_i != nxt);
  // wrap bursts keep the bits above the wrap window and roll the beat index inside it
  assign inc = req_adr + AW'(BW);
  assign msk = bte_q == 2'd1 ? AW'(4 * BW - 1) : bte_q == 2'd2 ? AW'(8 * BW - 1) : AW'(16 * BW - 1);
  assign nxt_d = cti_q == 3'b001 ? req_adr : cti_q != 3'b010 ? nxt :
                 bte_q == 2'd0 ? inc : (req_adr & ~msk) | (inc & msk);

  // next state: capture in IDLE, wait for the user (or a rejected beat) in WAIT, one termination cycle in RESP
  always_comb begin
    state_d = state;
    cap = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: begin
        cap = go;
        state_d = go ? WAIT : IDLE;
      end
      WAIT: begin
        fin = wb.wb_cyc_i & (bad | rsp_valid);
        state_d = !wb.wb_cyc_i ? IDLE : fin ? RESP : WAIT;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge wb_clk or negedge wb_rst)
    if (!wb_rst) state <= IDLE;
    else state <= state_d;

  // beat capture, termination, read data, next-address, burst tracking and cycle counters
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      wb.wb_dat_o <= '0;
      req_valid <= 1'b0;
      req_adr <= '0;
      req_we <= 1'b0;
      req_sel <= '0;
      req_wdat <= '0;
      req_burst <= 1'b0;
      req_first <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      cti_q <= '0;
      bte_q <= '0;
      bad <= 1'b0;
      in_burst <= 1'b0;
      nxt <= '0;
    end else begin
      wb.wb_ack_o <= fin & ~bad & ~rsp_err;
      wb.wb_err_o <= fin & (bad | rsp_err);
      if (cap) begin
        req_valid <= ~mis;
        req_adr <= wb.wb_adr_i;
        req_we <= wb.wb_we_i;
        req_sel <= wb.wb_sel_i;
        req_wdat <= wb.wb_dat_i;
        req_burst <= wb.wb_cti_i == 3'b001 || wb.wb_cti_i == 3'b010;
        req_first <= ~in_burst;
        cti_q <= wb.wb_cti_i;
        bte_q <= wb.wb_bte_i;
        bad <= mis;
        if (!in_burst && wb.wb_we_i) wr_cnt <= wr_cnt + 32'd1;
        if (!in_burst && !wb.wb_we_i) rd_cnt <= rd_cnt + 32'd1;
      end else if (state == WAIT && (fin || !wb.wb_cyc_i)) req_valid <= 1'b0;
      if (fin && !bad && !req_we && !rsp_err) wb.wb_dat_o <= rsp_rdat;
      if (fin && !bad) nxt <= nxt_d;
      if (fin) in_burst <= req_burst & ~bad & ~rsp_err;
      else if (!wb.wb_cyc_i && state != RESP) in_burst <= 1'b0;
    end
  end

`ifdef PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN
  // sticky flag for any burst beat whose address broke the expected sequence
  always_ff @(posedge wb_clk or negedge wb_rst)
    if (!wb_rst) adr_err <= 1'b0;
    else if (fin && bad) adr_err <= 1'b1;
`endif
endmodule

// File: tb/tb_peripheral_slave_bfm_wb.sv
// tb_peripheral_slave_bfm_wb: scoreboard bench for the Wishbone slave front-end
module tb_peripheral_slave_bfm_wb;
  typedef struct {logic [31:0] adr; logic we; logic [31:0] wdat; logic [3:0] sel; logic first; logic burst;} req_t;
  typedef struct {logic err; logic [31:0] dat; logic chk_dat;} rsp_t;
  typedef struct {int dly; logic err; logic [31:0] dat;} usr_t;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b0;
  logic req_valid, req_we, req_burst, req_first;
  logic rsp_valid, rsp_err;
  logic [31:0] req_adr, req_wdat, rsp_rdat, rd_cnt, wr_cnt;
  logic [3:0] req_sel;
`ifdef PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN
  logic adr_err;
`endif
  req_t exp_req[$];
  rsp_t exp_rsp[$];
  usr_t ursp[$];
  int pass = 0;
  int total = 0;

  always #5 wb_clk = ~wb_clk;

  peripheral_slave_bfm_wb_if #(.AW(32), .DW(32)) bus ();

  peripheral_slave_bfm_wb #(.AW(32), .DW(32)) dut (
    .wb_clk(wb_clk),
    .wb_rst(wb_rst),
    .wb(bus),
    .req_valid(req_valid),
    .req_adr(req_adr),
    .req_we(req_we),
    .req_sel(req_sel),
    .req_wdat(req_wdat),
    .req_burst(req_burst),
    .req_first(req_first),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_rdat(rsp_rdat),
    .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt)
`ifdef PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN
    ,
    .adr_err(adr_err)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else pass++;
  endtask

  // user side: answer each forwarded beat after the scripted delay
  initial begin
    usr_t u;
    rsp_valid = 1'b0;
    rsp_err = 1'b0;
    rsp_rdat = '0;
    forever begin
      @(negedge wb_clk);
      if (req_valid && ursp.size() > 0) begin
        u = ursp.pop_front();
        repeat (u.dly) @(negedge wb_clk);
        rsp_valid = 1'b1;
        rsp_err = u.err;
        rsp_rdat = u.dat;
        @(negedge wb_clk);
        rsp_valid = 1'b0;
        rsp_err = 1'b0;
      end
    end
  end

  // monitor: compare every raised request and every termination against the scoreboard
  initial begin
    logic prev;
    req_t r;
    rsp_t s;
    prev = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (req_valid && !prev) begin
        if (exp_req.size() == 0) begin
          total++;
          $display("FAIL req_unexpected got adr=%h exp none", req_adr);
        end else begin
          r = exp_req.pop_front();
          chk("req_adr", 64'(req_adr), 64'(r.adr));
          chk("req_we", 64'(req_we), 64'(r.we));
          chk("req_wdat", 64'(req_wdat), 64'(r.wdat));
          chk("req_sel", 64'(req_sel), 64'(r.sel));
          chk("req_first", 64'(req_first), 64'(r.first));
          chk("req_burst", 64'(req_burst), 64'(r.burst));
        end
      end
      prev = req_valid;
      if (bus.wb_ack_o || bus.wb_err_o) begin
        if (exp_rsp.size() == 0) begin
          total++;
          $display("FAIL rsp_unexpected got ack=%b err=%b exp none", bus.wb_ack_o, bus.wb_err_o);
        end else begin
          s = exp_rsp.pop_front();
          chk("rsp_err", 64'(bus.wb_err_o), 64'(s.err));
          chk("rsp_ack", 64'(bus.wb_ack_o), 64'(!s.err));
          if (s.chk_dat) chk("rsp_dat", 64'(bus.wb_dat_o), 64'(s.dat));
        end
      end
    end
  end

  // one beat: post expectations, drive the bus, wait (bounded) for termination
  task automatic beat(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] sel,
                      input logic [2:0] cti, input logic [1:0] bte, input logic last, input logic first,
                      input logic fwd, input int dly, input logic uerr, input logic [31:0] rdat, output int lat);
    int n;
    if (fwd) begin
      exp_req.push_back('{a, we, d, sel, first, cti == 3'b001 || cti == 3'b010});
      ursp.push_back('{dly, uerr, rdat});
    end
    exp_rsp.push_back('{uerr | !fwd, rdat, !we && !uerr && fwd});
    bus.wb_adr_i = a;
    bus.wb_we_i = we;
    bus.wb_dat_i = d;
    bus.wb_sel_i = sel;
    bus.wb_cti_i = cti;
    bus.wb_bte_i = bte;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge wb_clk);
      n++;
    end while (!(bus.wb_ack_o || bus.wb_err_o) && n < 50);
    if (n >= 50) begin
      total++;
      $display("FAIL beat_timeout got no termination exp ack/err adr=%h", a);
    end
    lat = n;
    @(posedge wb_clk);
    #1;
    if (last) begin
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got hang exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] lin_a[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] wrp_a[4] = '{32'h1C, 32'h10, 32'h14, 32'h18};
    logic [2:0] bcti[4] = '{3'b010, 3'b010, 3'b010, 3'b111};
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_we_i = 1'b0;
    bus.wb_cti_i = '0;
    bus.wb_bte_i = '0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_ack", 64'(bus.wb_ack_o), 64'd0);
    chk("rst_err", 64'(bus.wb_err_o), 64'd0);
    chk("rst_rty", 64'(bus.wb_rty_o), 64'd0);
    chk("rst_dat_o", 64'(bus.wb_dat_o), 64'd0);
    chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
`ifdef PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN
    chk("rst_adr_err", 64'(adr_err), 64'd0);
`endif
    wb_rst = 1'b1;
    @(posedge wb_clk);
    #1;
    // classic write, zero user delay: ack on the third negedge after driving
    beat(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h0, lat);
    chk("wr_lat", 64'(lat), 64'd3);
    chk("wr_cnt_1", 64'(wr_cnt), 64'd1);
    // classic read, user waits 3 clocks
    beat(32'h20, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00, 1'b1, 1'b1, 1'b1, 3, 1'b0, 32'h12345678, lat);
    chk("rd_lat", 64'(lat), 64'd6);
    chk("rd_cnt_1", 64'(rd_cnt), 64'd1);
    repeat (3) @(negedge wb_clk);
    chk("dat_o_hold", 64'(bus.wb_dat_o), 64'h12345678);
    @(posedge wb_clk);
    #1;
    // incrementing linear read burst
    for (int i = 0; i < 4; i++)
      beat(lin_a[i], 1'b0, 32'h0, 4'hF, bcti[i], 2'b00, i == 3, i == 0, 1'b1, i, 1'b0, 32'hA0 + 32'(i), lat);
    chk("rd_cnt_lin", 64'(rd_cnt), 64'd2);
    // wrap4 write burst from 0x1C
    for (int i = 0; i < 4; i++)
      beat(wrp_a[i], 1'b1, 32'h5500 + 32'(i), 4'h3, bcti[i], 2'b01, i == 3, i == 0, 1'b1, 0, 1'b0, 32'h0, lat);
    chk("wr_cnt_wrap", 64'(wr_cnt), 64'd2);
    // user error on beat 2 ends the burst
    beat(32'h200, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0, 32'hB0, lat);
    beat(32'h204, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00, 1'b1, 1'b0, 1'b1, 1, 1'b1, 32'hBAD, lat);
    chk("err_dat_kept", 64'(bus.wb_dat_o), 64'hB0);
    chk("rd_cnt_err", 64'(rd_cnt), 64'd3);
    // next cycle starts fresh: first beat again and a counted read
    beat(32'h300, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00, 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'hC0FFEE, lat);
    chk("rd_cnt_after_err", 64'(rd_cnt), 64'd4);
`ifdef PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN
    // wrap4 expects 0x10 after 0x1C; 0x20 is rejected with err and not forwarded
    beat(32'h1C, 1'b0, 32'h0, 4'hF, 3'b010, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0, 32'hD0, lat);
    beat(32'h20, 1'b0, 32'h0, 4'hF, 3'b010, 2'b01, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0, lat);
    chk("adr_err_set", 64'(adr_err), 64'd1);
    chk("adr_err_lat", 64'(lat), 64'd3);
`endif
    // abort: cyc dropped while waiting for the user
    exp_req.push_back('{32'h40, 1'b1, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0});
    bus.wb_adr_i = 32'h40;
    bus.wb_we_i = 1'b1;
    bus.wb_dat_i = 32'hCAFEF00D;
    bus.wb_sel_i = 4'hF;
    bus.wb_cti_i = 3'b000;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    repeat (2) @(negedge wb_clk);
    chk("abort_req_up", 64'(req_valid), 64'd1);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(negedge wb_clk);
    chk("abort_req_down", 64'(req_valid), 64'd0);
    chk("abort_no_ack", 64'(bus.wb_ack_o), 64'd0);
    repeat (3) @(negedge wb_clk);
    chk("wr_cnt_abort", 64'(wr_cnt), 64'd3);
    // asynchronous reset in the middle of WAIT
    exp_req.push_back('{32'h50, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0});
    bus.wb_adr_i = 32'h50;
    bus.wb_we_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    repeat (2) @(negedge wb_clk);
    chk("rstw_req_up", 64'(req_valid), 64'd1);
    #1 wb_rst = 1'b0;
    #1;
    chk("rstw_req_valid", 64'(req_valid), 64'd0);
    chk("rstw_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rstw_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("rstw_dat_o", 64'(bus.wb_dat_o), 64'd0);
    chk("rstw_req_adr", 64'(req_adr), 64'd0);
`ifdef PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN
    chk("rstw_adr_err", 64'(adr_err), 64'd0);
`endif
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(negedge wb_clk);
    wb_rst = 1'b1;
    @(posedge wb_clk);
    #1;
    beat(32'h60, 1'b1, 32'h0BADCAFE, 4'h1, 3'b000, 2'b00, 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h0, lat);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_wr_cnt", 64'(wr_cnt), 64'd1);
    repeat (3) @(negedge wb_clk);
    chk("exp_req_drained", 64'(exp_req.size()), 64'd0);
    chk("exp_rsp_drained", 64'(exp_rsp.size()), 64'd0);
    chk("ursp_drained", 64'(ursp.size()), 64'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/peripheral_slave_bfm_wb.md
Name: peripheral_slave_bfm_wb

Overview:
- Synthesizable Wishbone B4 slave front-end for bench memory models and peripheral stubs.
- Decodes classic and registered-feedback burst cycles from a Wishbone master.
- Presents each beat to a simple user-side request/response port, and returns ack or err with user read data.
- Generates the expected next burst address internally and counts read and write cycles.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8. ADR_LSB = log2(DW/8).

Ports:
- wb_clk  in  1  clock; all logic on the rising edge.
- wb_rst  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  AW  byte address.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  DW/8  byte enables.
- wb_we_i  in  1  1 = write.
- wb_cti_i  in  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_cyc_i, wb_stb_i  in  1  cycle and strobe.
- wb_ack_o, wb_err_o, wb_rty_o  out  1  beat termination.
- wb_dat_o  out  DW  read data.
- req_valid  out  1  beat pending for the user.
- req_adr  out  AW  beat address.
- req_we  out  1  beat direction.
- req_sel  out  DW/8  beat byte mask.
- req_wdat  out  DW  beat write data.
- req_burst  out  1  cti is 001 or 010.
- req_first  out  1  first beat of the cycle.
- rsp_valid  in  1  user completes the pending beat.
- rsp_err  in  1  with rsp_valid, terminate the beat with err.
- rsp_rdat  in  DW  read data, sampled with rsp_valid.
- rd_cnt, wr_cnt  out  32  cycles started, by direction of the first beat.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, counters 0, next-address register 0.
- wb_rty_o is tied to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Waits for wb_cyc_i & wb_stb_i.
  - On that, latches adr, we, sel, dat_i and cti into req_*, and sets req_valid=1.
  - Sets req_first=1 and increments wr_cnt or rd_cnt; moves to WAIT.
- WAIT:
  - req_valid held high; req_* stable.
  - On rsp_valid: clears req_valid. If the beat is a read and rsp_err=0, loads wb_dat_o with rsp_rdat. Registers ack = ~rsp_err and err = rsp_err, then moves to RESP.
  - rsp_valid in the same cycle the request is raised is not possible; the minimum latency from strobe to ack is 2 clocks.
- RESP:
  - wb_ack_o or wb_err_o is high for exactly this one cycle.
  - If the beat was classic (cti 000), cti 111, or err was returned: next state IDLE.
  - Otherwise (burst continues): next state IDLE-burst, i.e. IDLE with req_first cleared on the next capture and no counter increment.
  - While in IDLE-burst, a capture with wb_cyc_i low aborts the burst and returns to plain IDLE.
- Next-address register (nxt), computed when entering RESP:
  - cti 001: nxt = beat address.
  - cti 010, bte 00: nxt = adr + DW/8.
  - cti 010, bte wrap-N (N=4/8/16): bits [ADR_LSB+log2(N)-1 : ADR_LSB] increment modulo N; all other bits unchanged.
  - cti 000 or 111: nxt unchanged.
- wb_dat_o: holds its value after RESP until the next read completes.
- Write data is never stored here; the user samples req_wdat.
- wb_cyc_i deasserted in WAIT:
  - The beat is abandoned, req_valid clears next cycle, state goes to IDLE.
  - rsp_valid arriving later is ignored.
  - No ack is issued.
- Reset asserted mid-cycle: immediate return to reset state; a pending request is dropped.
- Counters wrap from 0xFFFF_FFFF to 0.

Optional Feature:
- Macro: PERIPHERAL_SLAVE_BFM_WB_ADR_CHECK_EN.
- When defined, on every non-first burst beat captured, wb_adr_i is compared with nxt.
- On mismatch, the beat is not forwarded to the user (req_valid stays 0). wb_err_o is asserted for one cycle two clocks after capture, and the burst ends (state IDLE).
- A sticky output adr_err (1 bit, reset 0) is set and cleared only by reset.
- When undefined, no comparison is made, the adr_err port is absent, and wb_adr_i is always forwarded.

Test Plan:
- Classic write: adr 0x10, dat 0xDEADBEEF, sel 0xF.
  - req_valid within 1 clk with req_adr=0x10 and req_wdat=0xDEADBEEF.
  - rsp_valid → wb_ack_o 1 cycle later for one cycle; wr_cnt=1.
- Classic read with the user delaying rsp_valid by 3 clocks, rsp_rdat=0x12345678.
  - wb_ack_o high exactly one cycle, with wb_dat_o=0x12345678; rd_cnt=1.
- Incrementing linear burst, 4 beats from 0x100, cti 010,010,010,111.
  - Beat addresses 0x100, 0x104, 0x108, 0x10C.
  - req_first only on beat 1; rd_cnt increments by 1; return to IDLE after the cti=111 beat.
- Wrap4 burst starting at 0x1C (bte 01).
  - nxt sequence 0x10, 0x14, 0x18.
  - With ADR_CHECK_EN, a master issuing 0x20 instead gets wb_err_o and adr_err=1.
- Error response: rsp_valid with rsp_err=1 on beat 2 of a burst.
  - wb_err_o for one cycle, wb_ack_o stays 0, and the FSM returns to IDLE.
- Reset and abort:
  - wb_rst low during WAIT → all outputs 0 asynchronously.
  - Separately, dropping wb_cyc_i in WAIT gives no ack and req_valid=0 next clock.
